// File: rtl/mem_fill_engine.sv
// mem_fill_engine: programmable-range RAM initialiser with pattern select, stall, abort and done pulse
module mem_fill_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          rdy,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] last_addr,
    input  logic [DW-1:0] seed,
    input  logic          stall,
    input  logic          abort,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wrdata,
    output logic          wren,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic [1:0]    mode_q;
    logic [AW-1:0] start_q, last_q, offset, ptr;
    logic [DW-1:0] seed_q, pattern;
    logic          last_write;
    assign ptr        = start_q + offset;
    assign last_write = wren && (ptr == last_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? WRITE : IDLE;
            WRITE:   state_nxt = abort ? IDLE : last_write ? DONE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= '0;
            start_q <= '0;
            last_q  <= '0;
            seed_q  <= '0;
            offset  <= '0;
        end else if (state == IDLE && en) begin
            mode_q  <= mode;
            start_q <= start_addr;
            last_q  <= last_addr;
            seed_q  <= seed;
            offset  <= '0;
        end else if (wren && !last_write) begin
            offset  <= offset + 1'b1;
        end
    end
    // reverse pattern: (2^AW-1) - ptr is the bitwise complement in AW bits
    assign pattern = mode_q == 2'b00 ? DW'(ptr) :
                     mode_q == 2'b01 ? seed_q :
                     mode_q == 2'b10 ? DW'(~ptr) :
                                       seed_q + DW'(offset);
    always_comb begin
        rdy    = state == IDLE;
        done   = state == DONE;
        wren   = state == WRITE && !stall && !abort;
        addr   = state == WRITE ? ptr : '0;
        wrdata = state == WRITE ? pattern : '0;
    end
endmodule
